// File: rtl/degamma_pkg.sv
// Shared constants and types for the RGB565 inverse-gamma LUT stage.
package degamma_pkg;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int LW = 6;

   localparam logic [1:0] CH_R   = 2'd0;
   localparam logic [1:0] CH_G   = 2'd1;
   localparam logic [1:0] CH_B   = 2'd2;
   localparam logic [1:0] CH_RSV = 2'd3;

   typedef enum logic {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_e;

   // 5-bit R/B channels index the 64-entry table on even entries only
   function automatic logic [AW-1:0] idx_from5(input logic [4:0] chan_val);
      return {chan_val, 1'b0};
   endfunction

endpackage

// File: rtl/degamma_lut_bank.sv
// Two-bank 64x6 table for one colour channel: one write port, one registered read port.
module degamma_lut_bank
   import degamma_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic          wbank,
   input  logic [AW-1:0] waddr,
   input  logic [LW-1:0] wdata,
   input  logic          re,
   input  logic          rbank,
   input  logic [AW-1:0] raddr,
   output logic [LW-1:0] rdata
);

   localparam int DEPTH = 2 * (2 ** AW);

   logic [LW-1:0] mem_r [DEPTH];
   logic [LW-1:0] rdata_r;

   // table storage write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[{wbank, waddr}] <= wdata;
      end
   end

   // registered read, held while the pipeline is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[{rbank, raddr}];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/degamma_lut.sv
// RGB565 linearisation stage: double-buffered per-channel LUTs, frame-aligned swap,
// two-stage valid/ready pipeline with full backpressure.
module degamma_lut
   import degamma_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] pix_in,
   input  logic          in_valid,
   input  logic          in_sof,
   output logic          in_ready,
   output logic [DW-1:0] pix_out,
   output logic          out_valid,
   output logic          out_sof,
   input  logic          out_ready,
   input  logic          bypass,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_chan,
   input  logic [AW-1:0] cfg_addr,
   input  logic [LW-1:0] cfg_data,
   input  logic          cfg_commit,
   output logic          cfg_drop,
   output logic          swap_pending,
   output logic          tbl_valid
);

   swap_state_e   state_r;
   logic          active_r;
   logic          tbl_valid_r;
   logic          cfg_drop_r;

   logic          en_s;
   logic          accept_s;
   logic          empty_s;
   logic          swap_s;
   logic          bank_sel_s;
   logic          pass_s;
   logic          drop_s;
   logic [2:0]    lut_we_s;

   logic          s0_valid_r;
   logic          s0_sof_r;
   logic          s0_pass_r;
   logic          s0_bank_r;
   logic [AW-1:0] s0_r_idx_r;
   logic [AW-1:0] s0_g_idx_r;
   logic [AW-1:0] s0_b_idx_r;
   logic [DW-1:0] s0_pix_r;

   logic          out_valid_r;
   logic          out_sof_r;
   logic          s1_pass_r;
   logic [DW-1:0] s1_pix_r;

   logic [LW-1:0] r_lut_s;
   logic [LW-1:0] g_lut_s;
   logic [LW-1:0] b_lut_s;

   // handshake, swap qualification and config write decode
   always_comb begin
      en_s     = out_ready || !out_valid_r;
      accept_s = in_valid && en_s;
      empty_s  = !s0_valid_r && !out_valid_r && !in_valid;
      swap_s   = (state_r == SWAP_PENDING) && ((accept_s && in_sof) || empty_s);
      // the sof pixel that triggers the swap already sees the new bank
      bank_sel_s = swap_s ? ~active_r : active_r;
      pass_s     = bypass || !(tbl_valid_r || swap_s);
      drop_s     = cfg_we && ((state_r == SWAP_PENDING) || (cfg_chan == CH_RSV));
      lut_we_s   = 3'b000;
      if (cfg_we && !drop_s) begin
         case (cfg_chan)
            CH_R:    lut_we_s = 3'b001;
            CH_G:    lut_we_s = 3'b010;
            CH_B:    lut_we_s = 3'b100;
            default: lut_we_s = 3'b000;
         endcase
      end else begin
         lut_we_s = 3'b000;
      end
   end

   // swap FSM, active bank select and config drop pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= SWAP_IDLE;
         active_r    <= 1'b0;
         tbl_valid_r <= 1'b0;
         cfg_drop_r  <= 1'b0;
      end else begin
         cfg_drop_r <= drop_s;
         case (state_r)
            SWAP_IDLE: begin
               if (cfg_commit) begin
                  state_r <= SWAP_PENDING;
               end
            end
            SWAP_PENDING: begin
               if (swap_s) begin
                  state_r     <= SWAP_IDLE;
                  active_r    <= ~active_r;
                  tbl_valid_r <= 1'b1;
               end
            end
            default: state_r <= SWAP_IDLE;
         endcase
      end
   end

   // stage 0: capture indices, sof, pass flag and bank tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_r <= 1'b0;
         s0_sof_r   <= 1'b0;
         s0_pass_r  <= 1'b0;
         s0_bank_r  <= 1'b0;
         s0_r_idx_r <= '0;
         s0_g_idx_r <= '0;
         s0_b_idx_r <= '0;
         s0_pix_r   <= '0;
      end else if (en_s) begin
         s0_valid_r <= in_valid;
         s0_sof_r   <= in_sof && in_valid;
         s0_pass_r  <= pass_s;
         s0_bank_r  <= bank_sel_s;
         s0_r_idx_r <= idx_from5(pix_in[15:11]);
         s0_g_idx_r <= pix_in[10:5];
         s0_b_idx_r <= idx_from5(pix_in[4:0]);
         s0_pix_r   <= pix_in;
      end
   end

   // stage 1: output valid/sof and the raw pixel for pass-through
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_sof_r   <= 1'b0;
         s1_pass_r   <= 1'b0;
         s1_pix_r    <= '0;
      end else if (en_s) begin
         out_valid_r <= s0_valid_r;
         out_sof_r   <= s0_sof_r;
         s1_pass_r   <= s0_pass_r;
         s1_pix_r    <= s0_pix_r;
      end
   end

   degamma_lut_bank u_bank_r (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lut_we_s[0]),
      .wbank (~active_r),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (en_s),
      .rbank (s0_bank_r),
      .raddr (s0_r_idx_r),
      .rdata (r_lut_s)
   );

   degamma_lut_bank u_bank_g (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lut_we_s[1]),
      .wbank (~active_r),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (en_s),
      .rbank (s0_bank_r),
      .raddr (s0_g_idx_r),
      .rdata (g_lut_s)
   );

   degamma_lut_bank u_bank_b (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lut_we_s[2]),
      .wbank (~active_r),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (en_s),
      .rbank (s0_bank_r),
      .raddr (s0_b_idx_r),
      .rdata (b_lut_s)
   );

   assign pix_out      = s1_pass_r ? s1_pix_r
                                   : {r_lut_s[LW-1:1], g_lut_s, b_lut_s[LW-1:1]};
   assign out_valid    = out_valid_r;
   assign out_sof      = out_sof_r;
   assign in_ready     = en_s;
   assign cfg_drop     = cfg_drop_r;
   assign swap_pending = (state_r == SWAP_PENDING);
   assign tbl_valid    = tbl_valid_r;

endmodule
